neural_data_packer: RTL and testbench

//  Packs 16-bit acquisition samples into 32-bit words and buffers them in a FIFO.

---
 rtl/neural_data_packer.sv | 105 ++++++++++
 tb/tb_neural_data_packer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/neural_data_packer.sv
// Packs pairs of 16-bit samples into 32-bit words and queues them for the Xillybus read stream.
// Optional drop counter: define NEURAL_PACK_DROP_CNT_EN to add the drop_count output.
module neural_data_packer #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  bus_clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [15:0]           sample_data,
  input  logic                  user_r_neural_data_32_open,
  input  logic                  user_r_neural_data_32_rden,
  output logic [31:0]           user_r_neural_data_32_data,
  output logic                  user_r_neural_data_32_empty,
  output logic                  user_r_neural_data_32_eof,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   fill_level
`ifdef NEURAL_PACK_DROP_CNT_EN
  ,
  output logic [15:0]           drop_count
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FILL_MAX = DEPTH;
  localparam logic [DEPTH_LOG2:0]   FILL_ONE = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [15:0]           half;
  logic                  pending;
  logic                  accept;
  logic                  word_done;
  logic                  full;
  logic                  do_wr;
  logic                  do_rd;
  logic                  do_drop;
  logic [DEPTH_LOG2:0]   fill_next;

  assign accept    = user_r_neural_data_32_open & sample_valid;
  assign word_done = accept & pending;
  assign full      = (fill_level == FILL_MAX);
  // Fullness is judged before the edge, so a same-cycle pop never makes room for the write.
  assign do_wr     = word_done & ~full;
  assign do_drop   = word_done & full;
  assign do_rd     = user_r_neural_data_32_open & user_r_neural_data_32_rden &
                     ~user_r_neural_data_32_empty;
  assign user_r_neural_data_32_eof = 1'b0;

  always_comb begin
    fill_next = fill_level;
    case ({do_wr, do_rd})
      2'b10:   fill_next = fill_level + FILL_ONE;
      2'b01:   fill_next = fill_level - FILL_ONE;
      default: fill_next = fill_level;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (reset) begin
      wr_ptr                      <= '0;
      rd_ptr                      <= '0;
      fill_level                  <= '0;
      user_r_neural_data_32_empty <= 1'b1;
      half                        <= '0;
      pending                     <= 1'b0;
      overflow                    <= 1'b0;
    end else if (!user_r_neural_data_32_open) begin
      wr_ptr                      <= '0;
      rd_ptr                      <= '0;
      fill_level                  <= '0;
      user_r_neural_data_32_empty <= 1'b1;
      pending                     <= 1'b0;
      overflow                    <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      fill_level                  <= fill_next;
      user_r_neural_data_32_empty <= (fill_next == '0);
      if (accept) begin
        if (!pending) half <= sample_data;
        pending <= ~pending;
      end
      if (do_drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (do_wr) mem[wr_ptr] <= {sample_data, half};
  end

  always_ff @(posedge bus_clk) begin
    if (reset) user_r_neural_data_32_data <= '0;
    else if (do_rd) user_r_neural_data_32_data <= mem[rd_ptr];
  end

`ifdef NEURAL_PACK_DROP_CNT_EN
  always_ff @(posedge bus_clk) begin
    if (reset || !user_r_neural_data_32_open) drop_count <= '0;
    else if (do_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_neural_data_packer.sv
// Bench for neural_data_packer: queue-based reference model compared every cycle, plus directed literal checks.
module tb_neural_data_packer;

  localparam int D   = 10;
  localparam int MAX = 2 ** D;

  logic          bus_clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic [15:0]   sample_data = '0;
  logic          open_s = 1'b0;
  logic          rden = 1'b0;
  logic [31:0]   data;
  logic          empty;
  logic          eof;
  logic          overflow;
  logic [D:0]    fill_level;
`ifdef NEURAL_PACK_DROP_CNT_EN
  logic [15:0]   drop_count;
`endif

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  neural_data_packer #(.DEPTH_LOG2(D)) dut (
    .bus_clk                     (bus_clk),
    .reset                       (reset),
    .sample_valid                (sample_valid),
    .sample_data                 (sample_data),
    .user_r_neural_data_32_open  (open_s),
    .user_r_neural_data_32_rden  (rden),
    .user_r_neural_data_32_data  (data),
    .user_r_neural_data_32_empty (empty),
    .user_r_neural_data_32_eof   (eof),
    .overflow                    (overflow),
    .fill_level                  (fill_level)
`ifdef NEURAL_PACK_DROP_CNT_EN
    ,
    .drop_count                  (drop_count)
`endif
  );

  always #5 bus_clk = ~bus_clk;

  // Reference model: a queue of words plus the half-word the packer is holding.
  logic [31:0] exp_q[$];
  logic [15:0] m_half = '0;
  bit          m_pending = 1'b0;
  bit          m_overflow = 1'b0;
  logic [31:0] m_data = '0;
  int          m_drops = 0;

  always @(posedge bus_clk) begin
    bit was_full;
    if (reset) begin
      exp_q.delete();
      m_pending = 1'b0; m_half = '0; m_overflow = 1'b0; m_data = '0; m_drops = 0;
    end else if (!open_s) begin
      exp_q.delete();
      m_pending = 1'b0; m_overflow = 1'b0; m_drops = 0;
    end else begin
      was_full = (exp_q.size() == MAX);
      if (rden && exp_q.size() > 0) m_data = exp_q.pop_front();
      if (sample_valid) begin
        if (m_pending) begin
          if (was_full) begin
            m_overflow = 1'b1;
            if (m_drops < 65535) m_drops++;
          end else begin
            exp_q.push_back({sample_data, m_half});
          end
          m_pending = 1'b0;
        end else begin
          m_half = sample_data;
          m_pending = 1'b1;
        end
      end
    end
  end

  always @(negedge bus_clk) begin
    if (check_en) begin
      checks++;
      if (data !== m_data) begin
        errors++; $display("FAIL model_data: got %h expected %h at %0t", data, m_data, $time);
      end
      checks++;
      if (empty !== (exp_q.size() == 0)) begin
        errors++; $display("FAIL model_empty: got %b expected %b at %0t", empty, exp_q.size() == 0, $time);
      end
      checks++;
      if (fill_level !== (D+1)'(exp_q.size())) begin
        errors++; $display("FAIL model_fill: got %0d expected %0d at %0t", fill_level, exp_q.size(), $time);
      end
      checks++;
      if (overflow !== m_overflow) begin
        errors++; $display("FAIL model_overflow: got %b expected %b at %0t", overflow, m_overflow, $time);
      end
      checks++;
      if (eof !== 1'b0) begin
        errors++; $display("FAIL model_eof: got %b expected 0 at %0t", eof, $time);
      end
`ifdef NEURAL_PACK_DROP_CNT_EN
      checks++;
      if (drop_count !== 16'(m_drops)) begin
        errors++; $display("FAIL model_drop_count: got %0d expected %0d at %0t", drop_count, m_drops, $time);
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs (called at a negedge), then advance to the next negedge.
  task automatic step(input logic v, input logic [15:0] d, input logic r);
    sample_valid = v; sample_data = d; rden = r;
    @(negedge bus_clk);
    sample_valid = 1'b0; rden = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    @(negedge bus_clk);
    reset = 1'b1;
    idle(2);
    check_en = 1'b1;
    chk("reset_data", data, 32'h0);
    chk("reset_empty", {31'b0, empty}, 32'h1);
    chk("reset_fill", {21'b0, fill_level}, 32'h0);
    chk("reset_overflow", {31'b0, overflow}, 32'h0);
    reset = 1'b0;
    open_s = 1'b1;
    idle(1);

    // Test 1: basic packing order and pops.
    step(1'b1, 16'h0001, 1'b0);
    step(1'b1, 16'h0002, 1'b0);
    step(1'b1, 16'h0003, 1'b0);
    step(1'b1, 16'h0004, 1'b0);
    chk("t1_fill", {21'b0, fill_level}, 32'd2);
    step(1'b0, 16'h0, 1'b1);
    chk("t1_word0", data, 32'h00020001);
    step(1'b0, 16'h0, 1'b1);
    chk("t1_word1", data, 32'h00040003);
    chk("t1_empty", {31'b0, empty}, 32'h1);

    // Test 4: reading while empty is ignored.
    step(1'b0, 16'h0, 1'b1);
    chk("t4_data_hold", data, 32'h00040003);
    chk("t4_empty", {31'b0, empty}, 32'h1);
    chk("t4_fill", {21'b0, fill_level}, 32'h0);

    // Test 2: fill to capacity, then one extra word is dropped.
    for (int i = 0; i < MAX; i++) begin
      step(1'b1, 16'(2 * i), 1'b0);
      step(1'b1, 16'(2 * i + 1), 1'b0);
    end
    chk("t2_full_fill", {21'b0, fill_level}, 32'(MAX));
    chk("t2_no_overflow_yet", {31'b0, overflow}, 32'h0);
    step(1'b1, 16'hDEAD, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0);
    chk("t2_overflow", {31'b0, overflow}, 32'h1);
    chk("t2_fill_max", {21'b0, fill_level}, 32'(MAX));
`ifdef NEURAL_PACK_DROP_CNT_EN
    chk("t2_drop_count", {16'b0, drop_count}, 32'd1);
`endif
    step(1'b0, 16'h0, 1'b1);
    chk("t2_first_word", data, 32'h00010000);

    // Refill to full, then test 3: pop and completing sample in the same cycle.
    step(1'b1, 16'h5555, 1'b0);
    step(1'b1, 16'h6666, 1'b0);
    chk("t3_refull", {21'b0, fill_level}, 32'(MAX));
    step(1'b1, 16'h7777, 1'b0);
    step(1'b1, 16'h8888, 1'b1);
    chk("t3_fill_max_m1", {21'b0, fill_level}, 32'(MAX - 1));
    chk("t3_overflow", {31'b0, overflow}, 32'h1);
    chk("t3_pop_word", data, 32'h00030002);
`ifdef NEURAL_PACK_DROP_CNT_EN
    chk("t3_drop_count", {16'b0, drop_count}, 32'd2);
`endif
    for (int i = 0; i < MAX - 1; i++) step(1'b0, 16'h0, 1'b1);
    chk("t3_last_word", data, 32'h66665555);
    chk("t3_drained", {31'b0, empty}, 32'h1);

    // Test 5: close with a half-word pending, reopen.
    step(1'b1, 16'hAAAA, 1'b0);
    open_s = 1'b0;
    idle(1);
    chk("t5_flush_overflow", {31'b0, overflow}, 32'h0);
    open_s = 1'b1;
    idle(1);
    step(1'b1, 16'h1111, 1'b0);
    step(1'b1, 16'h2222, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    chk("t5_word", data, 32'h22221111);
    chk("t5_overflow", {31'b0, overflow}, 32'h0);

    // Test 6: reset with 5 words queued and a half-word pending.
    for (int i = 0; i < 11; i++) step(1'b1, 16'(16'h0100 + i), 1'b0);
    chk("t6_fill_before", {21'b0, fill_level}, 32'd5);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("t6_empty", {31'b0, empty}, 32'h1);
    chk("t6_fill", {21'b0, fill_level}, 32'h0);
    chk("t6_data", data, 32'h0);
    step(1'b1, 16'h3333, 1'b0);
    step(1'b1, 16'h4444, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    chk("t6_pending_cleared", data, 32'h44443333);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
